f9pcap_port_arb: RTL and testbench

Packet-level round-robin arbiter that shares one udp_eth_send instance among PORT_COUNT f9phdr_wrap capture streams.
- Each requester presents a complete, buffered f9phdr-wrapped frame: valid/ready/data/keep/last plus a payload length.
- The block grants one port at a time, locks the grant until that frame's last beat, then rotates.
- Result: several capture ports feed one multicast UDP output link.

---
 rtl/f9pcap_port_arb.sv | 158 +++++++++++++++
 tb/tb_f9pcap_port_arb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f9pcap_port_arb.sv
// Packet-level round-robin arbiter: muxes PORT_COUNT buffered frame streams onto one
// udp_eth_send input, locking the grant from arbitration until the frame's last beat.

module f9pcap_port_arb_lane #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  grant,
  input  logic                  valid,
  input  logic                  en,
  input  logic                  last,
  input  logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [KEEP_WIDTH-1:0] keep,
  output logic                  req,
  output logic                  ready,
  output logic                  g_valid,
  output logic                  g_last,
  output logic [DATA_WIDTH-1:0] g_data,
  output logic [KEEP_WIDTH-1:0] g_keep
);
  // Ungranted lanes contribute zeros so the top can OR-reduce instead of muxing.
  assign req     = valid & en;
  assign ready   = grant & o_ready;
  assign g_valid = grant & valid;
  assign g_last  = g_valid & last;
  assign g_data  = g_valid ? data : '0;
  assign g_keep  = g_valid ? keep : '0;
endmodule

module f9pcap_port_arb #(
  parameter  int PORT_COUNT = 4,
  parameter  int DATA_WIDTH = 64,
  parameter  int LEN_WIDTH  = 16,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8,
  localparam int SEL_WIDTH  = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic [PORT_COUNT-1:0]            port_en_in,
  input  logic [PORT_COUNT-1:0]            i_valid_in,
  output logic [PORT_COUNT-1:0]            i_ready_out,
  input  logic [PORT_COUNT*DATA_WIDTH-1:0] i_data_in,
  input  logic [PORT_COUNT*KEEP_WIDTH-1:0] i_keep_in,
  input  logic [PORT_COUNT-1:0]            i_last_in,
  input  logic [PORT_COUNT*LEN_WIDTH-1:0]  i_data_len_in,
  output logic                             o_valid_out,
  input  logic                             o_ready_in,
  output logic [DATA_WIDTH-1:0]            o_data_out,
  output logic [KEEP_WIDTH-1:0]            o_keep_out,
  output logic                             o_last_out,
  output logic [LEN_WIDTH-1:0]             o_data_len_out,
  output logic [SEL_WIDTH-1:0]             o_sel_out,
  output logic                             o_busy_out,
  output logic [31:0]                      o_frame_cnt_out
);
  typedef enum logic {IDLE, PASS} state_t;

  state_t                                 state, state_nx;
  logic [SEL_WIDTH-1:0]                   sel, rr_ptr, win, idx;
  logic [LEN_WIDTH-1:0]                   len;
  logic [31:0]                            frame_cnt;
  logic                                   found, xfer_last;
  logic [PORT_COUNT-1:0]                  req, grant, g_valid, g_last;
  logic [PORT_COUNT-1:0][DATA_WIDTH-1:0]  data_a, g_data;
  logic [PORT_COUNT-1:0][KEEP_WIDTH-1:0]  keep_a, g_keep;
  logic [PORT_COUNT-1:0][LEN_WIDTH-1:0]   len_a;

  assign data_a = i_data_in;
  assign keep_a = i_keep_in;
  assign len_a  = i_data_len_in;

  always_comb begin
    grant = '0;
    if (state == PASS) grant[sel] = 1'b1;
  end

  for (genvar p = 0; p < PORT_COUNT; p++) begin : g_lane
    f9pcap_port_arb_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .KEEP_WIDTH (KEEP_WIDTH)
    ) u_lane (
      .grant   (grant[p]),
      .valid   (i_valid_in[p]),
      .en      (port_en_in[p]),
      .last    (i_last_in[p]),
      .o_ready (o_ready_in),
      .data    (data_a[p]),
      .keep    (keep_a[p]),
      .req     (req[p]),
      .ready   (i_ready_out[p]),
      .g_valid (g_valid[p]),
      .g_last  (g_last[p]),
      .g_data  (g_data[p]),
      .g_keep  (g_keep[p])
    );
  end

  always_comb begin
    o_data_out = '0;
    o_keep_out = '0;
    for (int p = 0; p < PORT_COUNT; p++) begin
      o_data_out = o_data_out | g_data[p];
      o_keep_out = o_keep_out | g_keep[p];
    end
  end

  assign o_valid_out     = |g_valid;
  assign o_last_out      = |g_last;
  assign o_busy_out      = (state == PASS);
  assign o_sel_out       = o_busy_out ? sel : '0;
  assign o_data_len_out  = o_busy_out ? len : '0;
  assign o_frame_cnt_out = frame_cnt;
  assign xfer_last       = o_valid_out & o_ready_in & o_last_out;

  // Search upward from rr_ptr+1; the explicit wrap keeps non-power-of-two counts in range.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = rr_ptr;
    for (int i = 0; i < PORT_COUNT; i++) begin
      idx = (idx == SEL_WIDTH'(PORT_COUNT - 1)) ? '0 : idx + SEL_WIDTH'(1);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = PASS;
      PASS:    if (xfer_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      sel       <= '0;
      rr_ptr    <= SEL_WIDTH'(PORT_COUNT - 1);
      len       <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        sel <= win;
        len <= len_a[win];
      end
      if (state == PASS && xfer_last) begin
        rr_ptr    <= sel;
        frame_cnt <= frame_cnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_f9pcap_port_arb.sv
// Bench for f9pcap_port_arb: cycle table, directed corner sequences, and a randomized
// run against a frame-level reference model.

module tb_f9pcap_port_arb;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int LW = 16;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    en, v, last, rdy;
  logic [N*DW-1:0] data;
  logic [N*KW-1:0] keep;
  logic [N*LW-1:0] lens;
  logic            ordy;
  logic            o_v, o_last, o_busy;
  logic [DW-1:0]   o_data;
  logic [KW-1:0]   o_keep;
  logic [LW-1:0]   o_len;
  logic [SW-1:0]   o_sel;
  logic [31:0]     o_cnt;

  int checks = 0;
  int errors = 0;

  f9pcap_port_arb #(.PORT_COUNT(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .port_en_in      (en),
    .i_valid_in      (v),
    .i_ready_out     (rdy),
    .i_data_in       (data),
    .i_keep_in       (keep),
    .i_last_in       (last),
    .i_data_len_in   (lens),
    .o_valid_out     (o_v),
    .o_ready_in      (ordy),
    .o_data_out      (o_data),
    .o_keep_out      (o_keep),
    .o_last_out      (o_last),
    .o_data_len_out  (o_len),
    .o_sel_out       (o_sel),
    .o_busy_out      (o_busy),
    .o_frame_cnt_out (o_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [N-1:0]  v, en, l;
    logic          r;
    logic          ev;
    logic [N-1:0]  erdy;
    logic [SW-1:0] esel;
    logic          eb, el;
    logic [LW-1:0] elen;
    logic [31:0]   ecnt;
  } vec_t;

  function automatic vec_t mk(input logic [N-1:0] vv, ee, ll, input logic r, ev,
                              input logic [N-1:0] erdy, input int esel,
                              input logic eb, el, input int elen, ecnt);
    vec_t t;
    t.v = vv; t.en = ee; t.l = ll; t.r = r; t.ev = ev; t.erdy = erdy;
    t.esel = SW'(esel); t.eb = eb; t.el = el; t.elen = LW'(elen); t.ecnt = 32'(ecnt);
    return t;
  endfunction

  function automatic logic [DW-1:0] mkdata(input int p, input int f, input int b);
    return {8'(p), 24'(f), 32'(b * 40503 + p)};
  endfunction

  function automatic logic [KW-1:0] mkkeep(input int p, input int f, input int b);
    return KW'(p * 37 + f * 11 + b * 5 + 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input logic ev, input logic [N-1:0] erdy, input logic [DW-1:0] ed,
                     input logic [KW-1:0] ek, input logic el, input logic [SW-1:0] es,
                     input logic eb, input logic [LW-1:0] elen, input logic [31:0] ec);
    check("o_valid", 64'(o_v), 64'(ev));
    check("i_ready", 64'(rdy), 64'(erdy));
    check("o_data", o_data, ed);
    check("o_keep", 64'(o_keep), 64'(ek));
    check("o_last", 64'(o_last), 64'(el));
    check("o_sel", 64'(o_sel), 64'(es));
    check("o_busy", 64'(o_busy), 64'(eb));
    check("o_data_len", 64'(o_len), 64'(elen));
    check("o_frame_cnt", 64'(o_cnt), 64'(ec));
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    v = '0; last = '0; en = '0; ordy = 1'b0; data = '0; keep = '0; lens = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  vec_t tbl[22];

  // Reference model state for the random run
  int          fr[N], bt[N], nb[N];
  logic [LW-1:0] flen[N];
  bit          m_busy;
  int          m_sel, m_ptr;
  logic [LW-1:0] m_len;
  logic [31:0] m_cnt;

  initial begin
    tbl[0]  = mk(4'h4, 4'hF, 4'h0, 1, 0, 4'h0, 0, 0, 0,  0, 0);
    tbl[1]  = mk(4'h4, 4'hF, 4'h0, 1, 1, 4'h4, 2, 1, 0, 37, 0);
    tbl[2]  = mk(4'h4, 4'hF, 4'h0, 1, 1, 4'h4, 2, 1, 0, 37, 0);
    tbl[3]  = mk(4'h4, 4'hF, 4'h0, 1, 1, 4'h4, 2, 1, 0, 37, 0);
    tbl[4]  = mk(4'h4, 4'hF, 4'h0, 1, 1, 4'h4, 2, 1, 0, 37, 0);
    tbl[5]  = mk(4'h4, 4'hF, 4'h4, 1, 1, 4'h4, 2, 1, 1, 37, 0);
    tbl[6]  = mk(4'h0, 4'hF, 4'h0, 1, 0, 4'h0, 0, 0, 0,  0, 1);
    tbl[7]  = mk(4'h6, 4'hB, 4'h0, 1, 0, 4'h0, 0, 0, 0,  0, 1);
    tbl[8]  = mk(4'h6, 4'hB, 4'h2, 1, 1, 4'h2, 1, 1, 1, 36, 1);
    tbl[9]  = mk(4'h6, 4'hB, 4'h0, 1, 0, 4'h0, 0, 0, 0,  0, 2);
    tbl[10] = mk(4'h6, 4'hB, 4'h2, 1, 1, 4'h2, 1, 1, 1, 36, 2);
    tbl[11] = mk(4'h6, 4'hB, 4'h0, 1, 0, 4'h0, 0, 0, 0,  0, 3);
    tbl[12] = mk(4'h6, 4'h9, 4'h0, 1, 1, 4'h2, 1, 1, 0, 36, 3);
    tbl[13] = mk(4'h6, 4'h9, 4'h2, 1, 1, 4'h2, 1, 1, 1, 36, 3);
    tbl[14] = mk(4'h6, 4'h9, 4'h0, 1, 0, 4'h0, 0, 0, 0,  0, 4);
    tbl[15] = mk(4'h6, 4'h9, 4'h0, 1, 0, 4'h0, 0, 0, 0,  0, 4);
    tbl[16] = mk(4'h1, 4'hF, 4'h0, 1, 0, 4'h0, 0, 0, 0,  0, 4);
    tbl[17] = mk(4'h1, 4'hF, 4'h0, 1, 1, 4'h1, 0, 1, 0, 35, 4);
    tbl[18] = mk(4'h1, 4'hF, 4'h0, 0, 1, 4'h0, 0, 1, 0, 35, 4);
    tbl[19] = mk(4'h1, 4'hF, 4'h0, 0, 1, 4'h0, 0, 1, 0, 35, 4);
    tbl[20] = mk(4'h1, 4'hF, 4'h1, 1, 1, 4'h1, 0, 1, 1, 35, 4);
    tbl[21] = mk(4'h0, 4'hF, 4'h0, 1, 0, 4'h0, 0, 0, 0,  0, 5);

    // Reset state
    do_reset();
    rst_n = 1'b0;
    #1 cmp(0, '0, '0, '0, 0, '0, 0, '0, '0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Cycle table: single requester, masking, mid-frame enable clear, backpressure
    for (int i = 0; i < 22; i++) begin
      v = tbl[i].v; en = tbl[i].en; last = tbl[i].l; ordy = tbl[i].r;
      for (int p = 0; p < N; p++) begin
        data[p*DW +: DW] = mkdata(p, 0, i);
        keep[p*KW +: KW] = mkkeep(p, 0, i);
        lens[p*LW +: LW] = LW'(35 + p);
      end
      #1 cmp(tbl[i].ev, tbl[i].erdy,
             tbl[i].ev ? mkdata(int'(tbl[i].esel), 0, i) : '0,
             tbl[i].ev ? mkkeep(int'(tbl[i].esel), 0, i) : '0,
             tbl[i].el, tbl[i].esel, tbl[i].eb, tbl[i].elen, tbl[i].ecnt);
      @(posedge clk); #1;
    end

    // Reset during beat 3 of a 10-beat port-1 frame
    v = 4'b0010; en = 4'hF; last = '0; ordy = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    #1 check("rst_pre_busy", 64'(o_busy), 64'd1);
    check("rst_pre_sel", 64'(o_sel), 64'd1);
    rst_n = 1'b0;
    #1 cmp(0, '0, '0, '0, 0, '0, 0, '0, '0);
    #1 rst_n = 1'b1;
    v = 4'b0011;
    @(posedge clk); #2;
    check("rst_post_busy", 64'(o_busy), 64'd1);
    check("rst_post_sel", 64'(o_sel), 64'd0);

    // All ports requesting continuously with 3-beat frames
    do_reset();
    begin
      int bt2[N];
      int order[$];
      int beats = 0, last_cyc = -1;
      bit oh_ok = 1'b1, beats_ok = 1'b1;
      for (int p = 0; p < N; p++) bt2[p] = 0;
      en = 4'hF; ordy = 1'b1; v = 4'hF;
      for (int cyc = 0; cyc < 60 && order.size() < 6; cyc++) begin
        for (int p = 0; p < N; p++) last[p] = (bt2[p] == 2);
        #1;
        if (!$onehot0(rdy)) oh_ok = 1'b0;
        if (o_v && ordy) begin
          beats++;
          if (o_last) begin
            order.push_back(int'(o_sel));
            if (beats != 3) beats_ok = 1'b0;
            beats = 0;
            last_cyc = cyc;
          end
        end
        for (int p = 0; p < N; p++)
          if (v[p] && rdy[p]) bt2[p] = (bt2[p] == 2) ? 0 : bt2[p] + 1;
        @(posedge clk); #1;
      end
      check("rr_frames", 64'(order.size()), 64'd6);
      for (int k = 0; k < order.size(); k++) check("rr_order", 64'(order[k]), 64'(k % N));
      check("rr_last_cycle", 64'(last_cyc), 64'd23);
      check("rr_ready_onehot", 64'(oh_ok), 64'd1);
      check("rr_burst_beats", 64'(beats_ok), 64'd1);
    end

    // Frame counter wrap
    do_reset();
    dut.frame_cnt = 32'hFFFF_FFFF;
    v = 4'b0001; last = 4'b0001; en = 4'hF; ordy = 1'b1;
    #1 check("wrap_preload", 64'(o_cnt), 64'hFFFF_FFFF);
    @(posedge clk); #2;
    check("wrap_last_beat", 64'(o_last & o_v), 64'd1);
    @(posedge clk); #1;
    v = '0;
    #1 check("wrap_cnt", 64'(o_cnt), 64'd0);
    check("wrap_idle", 64'(o_busy), 64'd0);

    // Randomized traffic against the frame-level model
    do_reset();
    for (int p = 0; p < N; p++) begin
      fr[p] = 0; bt[p] = 0; nb[p] = $urandom_range(1, 6); flen[p] = LW'($urandom);
    end
    m_busy = 1'b0; m_sel = 0; m_ptr = N - 1; m_len = '0; m_cnt = '0;
    en = 4'hF;
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] erdy;
      logic ev;
      for (int p = 0; p < N; p++) begin
        v[p] = ($urandom_range(0, 3) != 0);
        data[p*DW +: DW] = mkdata(p, fr[p], bt[p]);
        keep[p*KW +: KW] = mkkeep(p, fr[p], bt[p]);
        last[p] = (bt[p] == nb[p] - 1);
        lens[p*LW +: LW] = flen[p];
      end
      if ($urandom_range(0, 15) == 0) en = 4'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      #1;
      ev   = m_busy && v[m_sel];
      erdy = (m_busy && ordy) ? N'(1 << m_sel) : '0;
      cmp(ev, erdy,
          ev ? mkdata(m_sel, fr[m_sel], bt[m_sel]) : '0,
          ev ? mkkeep(m_sel, fr[m_sel], bt[m_sel]) : '0,
          ev && (bt[m_sel] == nb[m_sel] - 1),
          m_busy ? SW'(m_sel) : '0, m_busy, m_busy ? m_len : '0, m_cnt);
      if (m_busy) begin
        if (v[m_sel] && ordy) begin
          if (bt[m_sel] == nb[m_sel] - 1) begin
            fr[m_sel]++;
            bt[m_sel]   = 0;
            nb[m_sel]   = $urandom_range(1, 6);
            flen[m_sel] = LW'($urandom);
            m_busy      = 1'b0;
            m_ptr       = m_sel;
            m_cnt       = m_cnt + 32'd1;
          end else begin
            bt[m_sel]++;
          end
        end
      end else if ((v & en) != '0) begin
        for (int k = 1; k <= N; k++) begin
          int q;
          q = (m_ptr + k) % N;
          if (!m_busy && v[q] && en[q]) begin
            m_busy = 1'b1;
            m_sel  = q;
            m_len  = flen[q];
          end
        end
      end
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
